// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned HDR_W     = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: 2-bit byte index plus the bytes of the word in flight.
// The fourth byte completes the word as it is accepted, so only the first
// three bytes are held; word presents {held bytes, in_byte}.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [31:0]       word,
  output logic              last
);

  logic [1:0]            r_idx;
  logic [3*BYTE_W-1:0]   r_sr;

  // byte index and shift register; clr abandons any partial word
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx <= '0;
      r_sr  <= '0;
    end else if (clr) begin
      r_idx <= '0;
      r_sr  <= '0;
    end else if (shift_en) begin
      r_idx <= r_idx + 2'd1;
      r_sr  <= {r_sr[2*BYTE_W-1:0], in_byte};
    end
  end

  assign word = {r_sr, in_byte};
  assign last = (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: takes a length-prefixed byte stream,
// packs it big-endian into 32-bit words, writes them from address 0 and
// holds the CPU in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned      CNT_W    = HDR_W + 1;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
  logic [HDR_W-1:0]    r_n;
  // one bit wider than the address so a full-capacity image never wraps
  logic [ADDR_W:0]     r_word_cnt;

  logic                w_accept;
  logic                w_restart;
  logic                w_pk_shift;
  logic                w_pk_clr;
  logic                w_pk_last;
  logic [31:0]         w_pk_word;
  logic [HDR_W-1:0]    w_hdr_n;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last_word;

  assign w_accept    = in_valid && r_in_ready;
  assign w_restart   = start && ((r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_pk_shift  = w_accept && (r_state == ST_DATA);
  assign w_pk_clr    = (r_state == ST_WRITE) || w_restart;
  assign w_hdr_n     = {r_n[HDR_W-1:BYTE_W], in_data};
  assign w_cnt_inc   = CNT_W'(r_word_cnt) + CNT_W'(1);
  assign w_last_word = (w_cnt_inc == CNT_W'(r_n));

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_pk_clr),
    .shift_en (w_pk_shift),
    .in_byte  (in_data),
    .word     (w_pk_word),
    .last     (w_pk_last)
  );

  // load FSM; every output is registered and set on the edge entering its state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_HDR0;
      r_in_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_n          <= '0;
      r_word_cnt   <= '0;
    end else begin
      r_imem_we <= 1'b0;
      unique case (r_state)
        ST_HDR0: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_n[HDR_W-1:BYTE_W] <= in_data;
            r_state             <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (w_accept) begin
            r_n[BYTE_W-1:0] <= in_data;
            if (w_hdr_n == '0) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_rst  <= 1'b0;
            end else if (CNT_W'(w_hdr_n) > CAPACITY) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept && w_pk_last) begin
            r_state      <= ST_WRITE;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_word_cnt[ADDR_W-1:0];
            r_imem_wdata <= w_pk_word;
          end
        end
        ST_WRITE: begin
          r_word_cnt <= r_word_cnt + (ADDR_W+1)'(1);
          if (w_last_word) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state    <= ST_DATA;
            r_in_ready <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            r_state    <= ST_HDR0;
            r_in_ready <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_word_cnt <= '0;
          end
        end
        default: begin
          r_state    <= ST_HDR0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default 256-word instance plus a 16-word instance.
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready, a_start, a_we, a_cpu_rst, a_done, a_err;
  logic [7:0]  a_in_data, a_addr;
  logic [31:0] a_wdata;

  logic        b_rst, b_in_valid, b_in_ready, b_start, b_we, b_cpu_rst, b_done, b_err;
  logic [7:0]  b_in_data;
  logic [3:0]  b_addr;
  logic [31:0] b_wdata;

  imem_loader #(.ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .start(a_start), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .cpu_rst(a_cpu_rst), .done(a_done), .err(a_err)
  );

  imem_loader #(.ADDR_W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .start(b_start), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .cpu_rst(b_cpu_rst), .done(b_done), .err(b_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] a_wa[$], a_wd[$], b_wa[$], b_wd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write log, sampled mid-cycle
  always @(posedge clk) begin
    #2;
    if (a_we) begin a_wa.push_back(32'(a_addr)); a_wd.push_back(a_wdata); end
    if (b_we) begin b_wa.push_back(32'(b_addr)); b_wd.push_back(b_wdata); end
  end

  // present one byte (call at a negedge); returns at the negedge after it is accepted
  task automatic send(input bit sel, input logic [7:0] b);
    bit rdy;
    int unsigned guard;
    guard = 0;
    if (sel) begin b_in_data = b; b_in_valid = 1'b1; end
    else     begin a_in_data = b; a_in_valid = 1'b1; end
    forever begin
      rdy = sel ? b_in_ready : a_in_ready;
      @(negedge clk);
      if (rdy) break;
      guard++;
      if (guard > 40) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic drop(input bit sel);
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t5 [4];
    t5[0] = 8'hDE; t5[1] = 8'hAD; t5[2] = 8'hBE; t5[3] = 8'hEF;

    a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_start = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_start = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst", a_cpu_rst, 1);
    check("rst_done", a_done, 0);
    check("rst_err", a_err, 0);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_wdata", a_wdata, 0);
    check("rst_in_ready", a_in_ready, 0);
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);

    // 2: two-word image
    send(0, 8'h00); send(0, 8'h02);
    send(0, 8'h12); send(0, 8'h34); send(0, 8'h56);
    check("t2_cpu_rst_loading", a_cpu_rst, 1);
    check("t2_done_loading", a_done, 0);
    send(0, 8'h78);
    check("t2_w0_we", a_we, 1);
    check("t2_w0_ready", a_in_ready, 0);
    check("t2_w0_addr", a_addr, 0);
    check("t2_w0_data", a_wdata, 32'h12345678);
    send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC); send(0, 8'hDD);
    drop(0);
    check("t2_w1_we", a_we, 1);
    check("t2_w1_addr", a_addr, 1);
    check("t2_w1_data", a_wdata, 32'hAABBCCDD);
    @(negedge clk);
    check("t2_done", a_done, 1);
    check("t2_cpu_rst", a_cpu_rst, 0);
    check("t2_we_idle", a_we, 0);
    check("t2_ready_done", a_in_ready, 0);
    check("t2_addr_hold", a_addr, 1);
    check("t2_wdata_hold", a_wdata, 32'hAABBCCDD);
    check("t2_nwrites", a_wa.size(), 2);

    // 3: empty image
    pulse_start(0);
    check("t3_start_done", a_done, 0);
    check("t3_start_cpu_rst", a_cpu_rst, 1);
    check("t3_start_ready", a_in_ready, 1);
    send(0, 8'h00); send(0, 8'h00);
    drop(0);
    check("t3_done", a_done, 1);
    check("t3_cpu_rst", a_cpu_rst, 0);
    check("t3_ready", a_in_ready, 0);
    check("t3_nwrites", a_wa.size(), 2);

    // 5: one word with in_valid gaps; byte offered during WRITE is ignored
    pulse_start(0);
    send(0, 8'h00); drop(0); @(negedge clk);
    send(0, 8'h01); drop(0); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send(0, t5[i]); drop(0);
      if (i < 3) @(negedge clk);
    end
    check("t5_we", a_we, 1);
    check("t5_ready_write", a_in_ready, 0);
    check("t5_addr", a_addr, 0);
    check("t5_data", a_wdata, 32'hDEADBEEF);
    a_in_data = 8'h99; a_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    drop(0);
    check("t5_done", a_done, 1);
    check("t5_nwrites", a_wa.size(), 3);

    // 6: reset mid-word discards it; start mid-DATA is ignored
    pulse_start(0);
    send(0, 8'h00); send(0, 8'h01); send(0, 8'hF1); send(0, 8'hF2);
    drop(0);
    pulse_start(0);
    check("t6_start_ignored_ready", a_in_ready, 1);
    check("t6_start_ignored_done", a_done, 0);
    a_rst = 1'b0;
    @(negedge clk);
    check("t6_rst_ready", a_in_ready, 0);
    a_rst = 1'b1;
    @(negedge clk);
    check("t6_rel_ready", a_in_ready, 1);
    send(0, 8'h00); send(0, 8'h01); send(0, 8'h01); send(0, 8'h02);
    drop(0);
    pulse_start(0);
    send(0, 8'h03); send(0, 8'h04);
    drop(0);
    check("t6_we", a_we, 1);
    check("t6_addr", a_addr, 0);
    check("t6_data", a_wdata, 32'h01020304);
    @(negedge clk);
    check("t6_done", a_done, 1);
    check("t6_nwrites", a_wa.size(), 4);

    // rst wins over start
    a_rst = 1'b0; a_start = 1'b1;
    @(negedge clk);
    check("prio_ready", a_in_ready, 0);
    check("prio_done", a_done, 0);
    check("prio_cpu_rst", a_cpu_rst, 1);
    a_rst = 1'b1; a_start = 1'b0;
    @(negedge clk);
    check("prio_rel_ready", a_in_ready, 1);

    // 4: 16-word instance, header 17 overflows
    send(1, 8'h00); send(1, 8'h11);
    drop(1);
    check("t4_err", b_err, 1);
    check("t4_ready", b_in_ready, 0);
    check("t4_cpu_rst", b_cpu_rst, 1);
    check("t4_done", b_done, 0);
    b_in_data = 8'h55; b_in_valid = 1'b1;
    repeat (3) @(negedge clk);
    drop(1);
    check("t4_err_sticky", b_err, 1);
    check("t4_nwrites", b_wa.size(), 0);
    pulse_start(1);
    check("t4_start_err", b_err, 0);
    check("t4_start_ready", b_in_ready, 1);
    check("t4_start_cpu_rst", b_cpu_rst, 1);

    // full-capacity image on the 16-word instance: last write at addr 15
    send(1, 8'h00); send(1, 8'h10);
    for (int k = 0; k < 64; k++) send(1, 8'(k));
    drop(1);
    @(negedge clk);
    check("cap_done", b_done, 1);
    check("cap_err", b_err, 0);
    check("cap_cpu_rst", b_cpu_rst, 0);
    check("cap_nwrites", b_wa.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < b_wa.size()) begin
        check("cap_addr", b_wa[i], 32'(i));
        check("cap_data", b_wd[i], {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
